// File: rtl/sodor_imem_pkg.sv
// Shared definitions for the Sodor instruction-memory responder.
//   XLEN              : instruction / address width
//   DEFAULT_NOP_INSTR : default instruction returned when no program word is available
//   imem_state_e      : request handshake states of the responder
package sodor_imem_pkg;

   localparam int XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } imem_state_e;

endpackage

// File: rtl/sodor_inst_fifo.sv
// Program FIFO for the instruction-memory responder.
//   clock, reset_n : clock and asynchronous active-low reset (pointers/count only)
//   push/push_data : write request; ignored while full
//   pop            : advance the head; ignored while empty
//   head           : word at the head of the FIFO (valid while !empty)
//   full/empty     : occupancy flags, decoded from the registered count
//   count          : number of occupied entries
module sodor_inst_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 32,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_en, pop_en;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   // The head is read directly so the responder can capture it on the acceptance edge.
   assign head    = mem[rd_ptr_q];

   // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; emptiness is tracked by count alone.
   always_ff @(posedge clock) begin
      if (push_en) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/sodor_imem_responder.sv
// Memory side of the Sodor core's imem interface: accepts one fetch at a time and,
// LATENCY cycles later, returns the next preloaded program word (or NOP).
//   clock, reset_n          : clock, asynchronous active-low reset
//   io_imem_req_*           : fetch request (valid/ready/addr)
//   io_imem_resp_*          : one-cycle response strobe and held instruction data
//   load_valid/ready/data   : program preload port into the FIFO
//   fifo_count              : occupied program entries
//   served_count            : responses issued, wraps at 256
//   misalign_err            : sticky, set when a non-word-aligned fetch is accepted
module sodor_imem_responder
   import sodor_imem_pkg::*;
#(
   parameter int          DEPTH     = 16,
   parameter int          LATENCY   = 1,
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR,
   localparam int         CW        = $clog2(DEPTH + 1)
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            io_imem_req_valid,
   output logic            io_imem_req_ready,
   input  logic [XLEN-1:0] io_imem_req_bits_addr,
   output logic            io_imem_resp_valid,
   output logic [XLEN-1:0] io_imem_resp_bits_data,
   input  logic            load_valid,
   output logic            load_ready,
   input  logic [XLEN-1:0] load_data,
   output logic [CW-1:0]   fifo_count,
   output logic [7:0]      served_count,
   output logic            misalign_err
);

   imem_state_e     state_q, state_d;
   logic [2:0]      lat_cnt_q, lat_cnt_d;
   logic [XLEN-1:0] pending_q, pending_d;
   logic [XLEN-1:0] resp_data_q, resp_data_d;
   logic [7:0]      served_q, served_d;
   logic            misalign_q, misalign_d;

   logic            fifo_pop, fifo_full, fifo_empty;
   logic [XLEN-1:0] fifo_head;
   logic            unused_addr_bits;

   // Only the low two bits matter for alignment; the PC itself does not index anything.
   assign unused_addr_bits = ^io_imem_req_bits_addr[XLEN-1:2];

   sodor_inst_fifo #(
      .DEPTH (DEPTH),
      .W     (XLEN)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (load_valid),
      .push_data (load_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d     = state_q;
      lat_cnt_d   = lat_cnt_q;
      pending_d   = pending_q;
      resp_data_d = resp_data_q;
      served_d    = served_q;
      misalign_d  = misalign_q;
      fifo_pop    = 1'b0;

      case (state_q)
         IDLE: begin
            if (io_imem_req_valid) begin
               if (io_imem_req_bits_addr[1:0] != 2'b00) begin
                  pending_d  = NOP_INSTR;
                  misalign_d = 1'b1;
               end else if (!fifo_empty) begin
                  pending_d = fifo_head;
                  fifo_pop  = 1'b1;
               end else begin
                  pending_d = NOP_INSTR;
               end
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d   = WAIT;
                  lat_cnt_d = 3'(LATENCY - 2);
               end
            end
         end
         WAIT: begin
            if (lat_cnt_q == 3'd0) state_d = RESP;
            else                   lat_cnt_d = lat_cnt_q - 3'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Response data and the served counter update on entry to RESP, so both are
      // already valid in the cycle resp_valid is high.
      if (state_d == RESP && state_q != RESP) begin
         resp_data_d = pending_d;
         served_d    = served_q + 8'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         lat_cnt_q   <= 3'd0;
         pending_q   <= NOP_INSTR;
         resp_data_q <= NOP_INSTR;
         served_q    <= 8'd0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lat_cnt_q   <= lat_cnt_d;
         pending_q   <= pending_d;
         resp_data_q <= resp_data_d;
         served_q    <= served_d;
         misalign_q  <= misalign_d;
      end
   end

   assign io_imem_req_ready      = (state_q == IDLE);
   assign io_imem_resp_valid     = (state_q == RESP);
   assign io_imem_resp_bits_data = resp_data_q;
   assign load_ready             = !fifo_full;
   assign served_count           = served_q;
   assign misalign_err           = misalign_q;

endmodule

// File: tb/tb_sodor_imem_responder.sv
module tb_sodor_imem_responder;

   localparam int          DEPTH = 16;
   localparam int          LAT   = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;

   // main instance (LATENCY = 4)
   logic        req_valid = 1'b0, req_ready, resp_valid, load_valid = 1'b0, load_ready, misalign_err;
   logic [31:0] req_addr = '0, resp_data, load_data = '0;
   logic [4:0]  fifo_count;
   logic [7:0]  served_count;

   // second instance (LATENCY = 1)
   logic        r1_req_valid = 1'b0, r1_req_ready, r1_resp_valid, r1_load_valid = 1'b0, r1_load_ready, r1_misalign;
   logic [31:0] r1_req_addr = '0, r1_resp_data, r1_load_data = '0;
   logic [4:0]  r1_fifo_count;
   logic [7:0]  r1_served;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   sodor_imem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .NOP_INSTR(NOP)) dut (
      .clock(clock), .reset_n(reset_n),
      .io_imem_req_valid(req_valid), .io_imem_req_ready(req_ready),
      .io_imem_req_bits_addr(req_addr),
      .io_imem_resp_valid(resp_valid), .io_imem_resp_bits_data(resp_data),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .fifo_count(fifo_count), .served_count(served_count), .misalign_err(misalign_err)
   );

   sodor_imem_responder #(.DEPTH(DEPTH), .LATENCY(1), .NOP_INSTR(NOP)) dut1 (
      .clock(clock), .reset_n(reset_n),
      .io_imem_req_valid(r1_req_valid), .io_imem_req_ready(r1_req_ready),
      .io_imem_req_bits_addr(r1_req_addr),
      .io_imem_resp_valid(r1_resp_valid), .io_imem_resp_bits_data(r1_resp_data),
      .load_valid(r1_load_valid), .load_ready(r1_load_ready), .load_data(r1_load_data),
      .fifo_count(r1_fifo_count), .served_count(r1_served), .misalign_err(r1_misalign)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] data;
      int          served;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] prog_q[$];
   int          cyc = 0;
   int          free_at = 0;
   int          served_m = 0;
   bit          err_m = 1'b0;
   logic [31:0] last_data = NOP;
   int          last_served = 0;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // One bench cycle: check registered outputs against the model, drive inputs,
   // then advance the model by the clock edge.
   task automatic step(input bit rv, input logic [31:0] ra, input bit lv,
                       input logic [31:0] ld, output bit accepted);
      bit   do_push;
      int   sz;
      exp_t e;
      @(negedge clock);
      chk("req_ready", req_ready, (cyc >= free_at));
      chk("load_ready", load_ready, (prog_q.size() < DEPTH));
      chk("fifo_count", fifo_count, prog_q.size());
      chk("misalign_err", misalign_err, err_m);
      req_valid  = rv;
      req_addr   = ra;
      load_valid = lv;
      load_data  = ld;
      accepted   = rv && (cyc >= free_at);
      sz         = prog_q.size();
      do_push    = lv && (sz < DEPTH);
      @(posedge clock);
      cyc++;
      if (accepted) begin
         if (ra[1:0] != 2'b00) begin
            e.data = NOP;
            err_m  = 1'b1;
         end else if (sz > 0) begin
            e.data = prog_q.pop_front();
         end else begin
            e.data = NOP;
         end
         served_m = (served_m + 1) % 256;
         e.served = served_m;
         e.due    = cyc + LAT - 1;
         exp_q.push_back(e);
         free_at  = cyc + LAT;
      end
      if (do_push) prog_q.push_back(ld);
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, a);
   endtask

   task automatic push_word(input logic [31:0] w);
      bit a;
      step(1'b0, 32'h0, 1'b1, w, a);
   endtask

   // Hold a request until the model says it was taken; bounded.
   task automatic request(input logic [31:0] addr);
      bit a;
      a = 1'b0;
      for (int i = 0; i < 4 * LAT + 8 && !a; i++) step(1'b1, addr, 1'b0, 32'h0, a);
      chk("request_accepted", a, 1);
   endtask

   task automatic check_reset_values();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, NOP);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_load_ready", load_ready, 1);
      chk("rst_served", served_count, 0);
      chk("rst_misalign", misalign_err, 0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      bit   exp_v;
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset_n) begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("resp_valid", resp_valid, exp_v);
            if (exp_v) begin
               e = exp_q.pop_front();
               chk("resp_data", resp_data, e.data);
               chk("served_count", served_count, e.served);
               last_data   = e.data;
               last_served = e.served;
               $display("resp cycle=%0d data=%08h served=%0d", cyc, resp_data, served_count);
            end else begin
               chk("resp_hold", resp_data, last_data);
               chk("served_hold", served_count, last_served);
            end
            while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      bit a;
      repeat (3) @(negedge clock);
      check_reset_values();
      #2 reset_n = 1'b1;

      // LATENCY = 1 instance: empty-FIFO fetch, then one loaded word
      @(negedge clock);
      r1_req_valid = 1'b1; r1_req_addr = 32'h0;
      @(negedge clock);
      r1_req_valid = 1'b0;
      chk("l1_resp_valid", r1_resp_valid, 1);
      chk("l1_resp_data", r1_resp_data, NOP);
      chk("l1_served", r1_served, 1);
      chk("l1_req_ready_busy", r1_req_ready, 0);
      r1_load_valid = 1'b1; r1_load_data = 32'h0050_0093;
      @(negedge clock);
      r1_load_valid = 1'b0;
      chk("l1_resp_valid_low", r1_resp_valid, 0);
      chk("l1_fifo_count", r1_fifo_count, 1);
      r1_req_valid = 1'b1; r1_req_addr = 32'h4;
      @(negedge clock);
      r1_req_valid = 1'b0;
      chk("l1_resp_data2", r1_resp_data, 32'h0050_0093);
      chk("l1_served2", r1_served, 2);
      @(negedge clock);
      chk("l1_hold", r1_resp_data, 32'h0050_0093);
      $display("txn latency1 checks done");

      // main instance: empty FIFO fetch
      request(32'h0);
      idle(LAT + 1);
      $display("txn empty-fifo fetch done");

      // preload two words, back-to-back fetches
      push_word(32'h0050_0093);
      push_word(32'h0010_8113);
      request(32'h0);
      request(32'h4);
      idle(LAT + 2);
      $display("txn back-to-back fetch done");

      // fill to full, 17th push ignored, then request + push while full
      for (int i = 0; i < DEPTH; i++) push_word(32'h1000_0000 + i);
      push_word(32'hdead_beef);
      step(1'b1, 32'h8, 1'b1, 32'hcafe_f00d, a);
      chk("full_req_accepted", a, 1);
      idle(LAT + 1);
      $display("txn full-fifo push/pop done");

      // misaligned fetch with non-empty FIFO
      request(32'h6);
      idle(LAT + 2);
      request(32'hc);
      idle(LAT + 2);
      $display("txn misaligned fetch done");

      // reset while in WAIT
      request(32'h10);
      idle(1);
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1 check_reset_values();
      exp_q.delete();
      prog_q.delete();
      served_m = 0; err_m = 1'b0; last_data = NOP; last_served = 0; free_at = cyc;
      req_valid = 1'b0; load_valid = 1'b0;
      repeat (2) @(negedge clock);
      #2 reset_n = 1'b1;
      idle(LAT + 4);
      $display("txn reset-in-wait done");

      // randomized traffic, long enough for served_count to wrap
      for (int i = 0; i < 1800; i++) begin
         logic [31:0] ra;
         ra = $urandom() & 32'hffff_fffc;
         if ($urandom_range(0, 15) == 0) ra[1:0] = 2'($urandom_range(1, 3));
         step($urandom_range(0, 9) < 8, ra, $urandom_range(0, 1) == 1, $urandom(), a);
      end
      idle(LAT + 2);
      $display("txn random traffic done served_model=%0d", served_m);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
